// File: rtl/gather.sv
// gather: N-lane join; buffers one word per lane and presents their concatenation once every lane is full.
// Define GATHER_REFILL_EN to let a lane reload on the same edge the gathered set is consumed.
module gather #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_stb,
  input  logic [N*W-1:0] s_dat,
  output logic [N-1:0]   s_rdy,
  input  logic           m_rdy,
  output logic           m_stb,
  output logic [N*W-1:0] m_dat,
  output logic [N-1:0]   pend
);

  logic [N-1:0]   vld_q, vld_d;
  logic [N*W-1:0] buf_q, buf_d;
  logic           fire;
  logic [N-1:0]   lane_rdy;
  logic [N-1:0]   take;

  assign m_stb = &vld_q;
  assign m_dat = buf_q;
  assign pend  = vld_q;
  assign fire  = m_stb & m_rdy;

`ifdef GATHER_REFILL_EN
  assign lane_rdy = ~vld_q | {N{fire}};
`else
  assign lane_rdy = ~vld_q;
`endif

  // Ready is masked during reset so upstream never counts a transfer the cleared flops drop.
  assign s_rdy = rst ? '0 : lane_rdy;
  assign take  = s_stb & lane_rdy;

  always_comb begin
    vld_d = fire ? '0 : vld_q;
    buf_d = buf_q;
    for (int i = 0; i < N; i++) begin
      if (take[i]) begin
        vld_d[i]        = 1'b1;
        buf_d[i*W +: W] = s_dat[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      buf_q <= '0;
    end else begin
      vld_q <= vld_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: tb/tb_gather.sv
// tb_gather: randomized scoreboard bench for gather (W=8, N=2); lane words are collected
// into per-lane queues and paired into expected output words that a negedge monitor checks.
module tb_gather;
  localparam int W = 8;
  localparam int N = 2;
`ifdef GATHER_REFILL_EN
  localparam bit REFILL = 1'b1;
`else
  localparam bit REFILL = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   s_stb;
  logic [N*W-1:0] s_dat;
  logic [N-1:0]   s_rdy;
  logic           m_rdy;
  logic           m_stb;
  logic [N*W-1:0] m_dat;
  logic [N-1:0]   pend;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] sendQ0[$];
  logic [W-1:0] sendQ1[$];
  int lanePct   = 100;
  bit rdyRandom = 1'b0;
  bit rdyFixed  = 1'b1;

  logic [W-1:0]   laneQ0[$];
  logic [W-1:0]   laneQ1[$];
  logic [N*W-1:0] expQ[$];
  int occ0 = 0;
  int occ1 = 0;
  bit holdValid = 1'b0;
  logic [N*W-1:0] holdDat;
  int cycle = 0;
  int fireCount = 0;
  int firstFire = -1;
  int lastFire = -1;
  logic           mExpStb;
  logic           mFire;
  logic [N-1:0]   mExpRdy;
  logic [W-1:0]   mW0, mW1;
  logic [N*W-1:0] mExp;

  gather #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_stb(s_stb),
    .s_dat(s_dat),
    .s_rdy(s_rdy),
    .m_rdy(m_rdy),
    .m_stb(m_stb),
    .m_dat(m_dat),
    .pend (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One lane word per accepted handshake enters its lane queue; whenever every lane has one,
  // the oldest of each is paired into the next expected output word.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      laneQ0.delete();
      laneQ1.delete();
      expQ.delete();
      occ0 = 0;
      occ1 = 0;
      holdValid = 1'b0;
      checkOutput("rst_s_rdy", 64'(s_rdy), 64'(0));
      checkOutput("rst_m_stb", 64'(m_stb), 64'(0));
      checkOutput("rst_pend", 64'(pend), 64'(0));
      checkOutput("rst_m_dat", 64'(m_dat), 64'(0));
    end else begin
      mExpStb    = (occ0 > 0) && (occ1 > 0);
      mFire      = mExpStb && m_rdy;
      mExpRdy[0] = (occ0 == 0) || (REFILL && mFire);
      mExpRdy[1] = (occ1 == 0) || (REFILL && mFire);
      checkOutput("m_stb", 64'(m_stb), 64'(mExpStb));
      checkOutput("pend", 64'(pend), 64'({occ1 != 0, occ0 != 0}));
      checkOutput("s_rdy", 64'(s_rdy), 64'(mExpRdy));
      if (holdValid && m_stb) checkOutput("m_dat_stable", 64'(m_dat), 64'(holdDat));
      if (mFire) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL m_dat_fire: got %0h expected no output word", m_dat);
        end else begin
          mExp = expQ.pop_front();
          checkOutput("m_dat_fire", 64'(m_dat), 64'(mExp));
        end
        fireCount++;
        if (firstFire < 0) firstFire = cycle;
        lastFire = cycle;
        occ0--;
        occ1--;
      end
      holdValid = m_stb && !m_rdy;
      holdDat   = m_dat;
      if (s_stb[0] && mExpRdy[0]) begin
        occ0++;
        laneQ0.push_back(s_dat[W-1:0]);
      end
      if (s_stb[1] && mExpRdy[1]) begin
        occ1++;
        laneQ1.push_back(s_dat[2*W-1:W]);
      end
      while (laneQ0.size() > 0 && laneQ1.size() > 0) begin
        mW0 = laneQ0.pop_front();
        mW1 = laneQ1.pop_front();
        expQ.push_back({mW1, mW0});
      end
    end
  end

  // Each lane behaves as a well-mannered upstream: once strobing it holds word and strobe until taken.
  task automatic applyStimulus(input int cycles);
    logic [N-1:0] acc;
    logic [W-1:0] tmp;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = s_stb & s_rdy;
      @(posedge clk);
      #1;
      if (acc[0]) tmp = sendQ0.pop_front();
      if (acc[1]) tmp = sendQ1.pop_front();
      if (!(s_stb[0] && !acc[0])) begin
        if (sendQ0.size() > 0 && int'($urandom_range(0, 99)) < lanePct) begin
          s_stb[0] = 1'b1;
          s_dat[W-1:0] = sendQ0[0];
        end else begin
          s_stb[0] = 1'b0;
          s_dat[W-1:0] = W'($urandom);
        end
      end
      if (!(s_stb[1] && !acc[1])) begin
        if (sendQ1.size() > 0 && int'($urandom_range(0, 99)) < lanePct) begin
          s_stb[1] = 1'b1;
          s_dat[2*W-1:W] = sendQ1[0];
        end else begin
          s_stb[1] = 1'b0;
          s_dat[2*W-1:W] = W'($urandom);
        end
      end
      m_rdy = rdyRandom ? 1'($urandom_range(0, 1)) : rdyFixed;
    end
  endtask

  initial begin
    rst   = 1'b0;
    s_stb = '0;
    s_dat = '0;
    m_rdy = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Both lanes on the same edge.
    rdyFixed = 1'b1;
    sendQ0.push_back(8'hA1);
    sendQ1.push_back(8'hB2);
    applyStimulus(1);
    checkOutput("t1_s_rdy_before", 64'(s_rdy), 64'(2'b11));
    applyStimulus(1);
    checkOutput("t1_m_stb", 64'(m_stb), 64'(1));
    checkOutput("t1_m_dat", 64'(m_dat), 64'(16'hB2A1));
    checkOutput("t1_pend", 64'(pend), 64'(2'b11));
    applyStimulus(1);
    checkOutput("t1_m_stb_after", 64'(m_stb), 64'(0));
    checkOutput("t1_pend_after", 64'(pend), 64'(0));
    applyStimulus(2);

    // Skewed lanes.
    sendQ0.push_back(8'h11);
    applyStimulus(3);
    sendQ1.push_back(8'h22);
    applyStimulus(6);

    // Backpressure with a lane0 retry.
    rdyFixed = 1'b0;
    sendQ0.push_back(8'h01);
    sendQ0.push_back(8'h33);
    sendQ1.push_back(8'h02);
    applyStimulus(7);
    checkOutput("bp_s_rdy", 64'(s_rdy), 64'(2'b00));
    checkOutput("bp_m_dat", 64'(m_dat), 64'(16'h0201));
    checkOutput("bp_retry_held", 64'(s_stb[0]), 64'(1));
    rdyFixed = 1'b1;
    sendQ1.push_back(8'h34);
    applyStimulus(6);

    // Asynchronous reset with lane0 partially gathered.
    sendQ0.push_back(8'h44);
    applyStimulus(2);
    checkOutput("pre_rst_pend", 64'(pend), 64'(2'b01));
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_pend", 64'(pend), 64'(0));
    checkOutput("async_rst_m_stb", 64'(m_stb), 64'(0));
    checkOutput("async_rst_s_rdy", 64'(s_rdy), 64'(0));
    applyStimulus(1);
    #2 rst = 1'b0;
    sendQ0.push_back(8'h55);
    sendQ1.push_back(8'h66);
    applyStimulus(6);

    // Continuous stream for throughput.
    fireCount = 0;
    firstFire = -1;
    for (int i = 0; i < 8; i++) begin
      sendQ0.push_back(W'($urandom));
      sendQ1.push_back(W'($urandom));
    end
    applyStimulus(30);
    checkOutput("stream_count", 64'(fireCount), 64'(8));
    checkOutput("stream_span", 64'(lastFire - firstFire), REFILL ? 64'(7) : 64'(14));

    // Random skew and random backpressure.
    fireCount = 0;
    lanePct   = 60;
    rdyRandom = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sendQ0.push_back(W'($urandom));
      sendQ1.push_back(W'($urandom));
    end
    for (int c = 0; c < 4000 && (sendQ0.size() > 0 || sendQ1.size() > 0); c++) applyStimulus(1);
    checkOutput("rand_timeout", 64'(sendQ0.size() + sendQ1.size()), 64'(0));
    rdyRandom = 1'b0;
    rdyFixed  = 1'b1;
    applyStimulus(10);
    checkOutput("rand_leftover", 64'(expQ.size()), 64'(0));
    checkOutput("rand_count", 64'(fireCount), 64'(200));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
